// File: rtl/dpram_port_arbiter_if.sv
// Requester-side bus of the dual-port RAM port arbiter.
// The arbiter is the slave; the requesters together form the master.
interface dpram_port_arbiter_if #(
    parameter int NREQ = 3,
    parameter int AW   = 8,
    parameter int DW   = 8
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    we;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    ack;
    logic [NREQ-1:0]    rvalid;
    logic [DW-1:0]      rdata;

    modport master (
        output req, we, addr, wdata,
        input  ack, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, rvalid, rdata
    );
endinterface

// File: rtl/dpram_port_arbiter.sv
// Shares one dual-port RAM port between NREQ requesters, one op per clock,
// round-robin or fixed priority, with per-requester read-valid pulses.
module dpram_port_arbiter #(
    parameter int NREQ       = 3,
    parameter int AW         = 8,
    parameter int DW         = 8,
    parameter int FIXED_PRIO = 0
) (
    input  logic          clock,
    input  logic          reset,
    dpram_port_arbiter_if.slave bus,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_data,
    output logic          mem_wren,
    output logic          mem_rden,
    input  logic [DW-1:0] mem_q
);
    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0] elig;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   gid;
    logic [IW-1:0]   sel;
    logic [IW-1:0]   nxt_ptr;
    logic            found;
    logic            sel_we;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;

    // A requester whose ack is high still shows a stale req this cycle.
    assign elig = bus.req & ~bus.ack;

    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (FIXED_PRIO != 0) begin
                idx = k;
            end else begin
                idx = int'(ptr) + k;
                if (idx >= NREQ) idx = idx - NREQ;
            end
            if (!found && elig[idx]) begin
                found = 1'b1;
                sel   = IW'(idx);
            end
        end
    end

    assign sel_we    = bus.we[sel];
    assign sel_addr  = bus.addr[int'(sel)*AW +: AW];
    assign sel_wdata = bus.wdata[int'(sel)*DW +: DW];
    assign nxt_ptr   = (sel == IW'(NREQ - 1)) ? '0 : sel + 1'b1;

    // RAM read is registered once, so q lines up with the delayed id.
    assign bus.rdata = mem_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            bus.ack     <= '0;
            bus.rvalid  <= '0;
            mem_address <= '0;
            mem_data    <= '0;
            mem_wren    <= 1'b0;
            mem_rden    <= 1'b0;
            gid         <= '0;
            ptr         <= '0;
        end else begin
            bus.rvalid <= mem_rden ? (NREQ'(1) << gid) : '0;
            if (found) begin
                bus.ack     <= NREQ'(1) << sel;
                mem_address <= sel_addr;
                mem_data    <= sel_wdata;
                mem_wren    <= sel_we;
                mem_rden    <= ~sel_we;
                gid         <= sel;
                if (FIXED_PRIO == 0) ptr <= nxt_ptr;
            end else begin
                bus.ack  <= '0;
                mem_wren <= 1'b0;
                mem_rden <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Directed bench: round-robin arbiter with a RAM model, plus a
// fixed-priority instance for the priority ordering scenario.
module tb_dpram_port_arbiter;
    logic clock;
    logic reset;
    int   checks;
    int   fails;

    dpram_port_arbiter_if #(.NREQ(3), .AW(8), .DW(8)) rbus ();
    dpram_port_arbiter_if #(.NREQ(3), .AW(8), .DW(8)) fbus ();

    logic [7:0] r_address, r_data, r_q;
    logic       r_wren, r_rden;
    logic [7:0] f_address, f_data, f_q;
    logic       f_wren, f_rden;
    logic [7:0] ram [256];

    dpram_port_arbiter #(.NREQ(3), .AW(8), .DW(8), .FIXED_PRIO(0)) dut (
        .clock(clock), .reset(reset), .bus(rbus),
        .mem_address(r_address), .mem_data(r_data),
        .mem_wren(r_wren), .mem_rden(r_rden), .mem_q(r_q)
    );

    dpram_port_arbiter #(.NREQ(3), .AW(8), .DW(8), .FIXED_PRIO(1)) dut_fp (
        .clock(clock), .reset(reset), .bus(fbus),
        .mem_address(f_address), .mem_data(f_data),
        .mem_wren(f_wren), .mem_rden(f_rden), .mem_q(f_q)
    );

    always #5 clock = ~clock;

    // Registered-read RAM behind the round-robin instance.
    always @(posedge clock) begin
        if (r_wren) ram[r_address] <= r_data;
        if (r_rden) r_q <= ram[r_address];
    end

    always @(posedge clock) begin
        if (f_rden) f_q <= f_address;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        rbus.req = '0; rbus.we = '0; rbus.addr = '0; rbus.wdata = '0;
        fbus.req = '0; fbus.we = '0; fbus.addr = '0; fbus.wdata = '0;
        do_reset();
        checks++;
        if (rbus.ack !== 3'b000) begin
            fails++; $display("FAIL reset_ack got %b want 000", rbus.ack);
        end
        checks++;
        if (rbus.rvalid !== 3'b000) begin
            fails++; $display("FAIL reset_rvalid got %b want 000", rbus.rvalid);
        end
        checks++;
        if ({r_wren, r_rden} !== 2'b00) begin
            fails++; $display("FAIL reset_wr_rd got %b want 00", {r_wren, r_rden});
        end
        checks++;
        if ({r_address, r_data} !== 16'h0000) begin
            fails++; $display("FAIL reset_addr_data got %h want 0000", {r_address, r_data});
        end
        checks++;
        if (fbus.ack !== 3'b000) begin
            fails++; $display("FAIL reset_fp_ack got %b want 000", fbus.ack);
        end
    endtask

    task automatic test_write();
        rbus.req = 3'b001; rbus.we = 3'b001;
        rbus.addr[7:0] = 8'h10; rbus.wdata[7:0] = 8'hA5;
        rbus.addr[23:8] = 16'hFFFF; rbus.wdata[23:8] = 16'hEEEE;
        tick();
        rbus.req = '0;
        checks++;
        if (rbus.ack !== 3'b001) begin
            fails++; $display("FAIL write_ack got %b want 001", rbus.ack);
        end
        checks++;
        if ({r_wren, r_rden} !== 2'b10) begin
            fails++; $display("FAIL write_wr_rd got %b want 10", {r_wren, r_rden});
        end
        checks++;
        if ({r_address, r_data} !== 16'h10A5) begin
            fails++; $display("FAIL write_addr_data got %h want 10a5", {r_address, r_data});
        end
        tick();
        checks++;
        if ({rbus.ack, rbus.rvalid, r_wren} !== 7'b0) begin
            fails++; $display("FAIL write_after got %b want 0000000",
                              {rbus.ack, rbus.rvalid, r_wren});
        end
    endtask

    task automatic test_read_back();
        rbus.req = 3'b010; rbus.we = 3'b000;
        rbus.addr[15:8] = 8'h10;
        tick();
        rbus.req = '0;
        checks++;
        if (rbus.ack !== 3'b010 || r_rden !== 1'b1) begin
            fails++; $display("FAIL read_ack got %b/%b want 010/1", rbus.ack, r_rden);
        end
        checks++;
        if (rbus.rvalid !== 3'b000) begin
            fails++; $display("FAIL read_early_rvalid got %b want 000", rbus.rvalid);
        end
        tick();
        checks++;
        if (rbus.rvalid !== 3'b010) begin
            fails++; $display("FAIL read_rvalid got %b want 010", rbus.rvalid);
        end
        checks++;
        if (rbus.rdata !== 8'hA5) begin
            fails++; $display("FAIL read_rdata got %h want a5", rbus.rdata);
        end
        tick();
        checks++;
        if (rbus.rvalid !== 3'b000) begin
            fails++; $display("FAIL read_rvalid_pulse got %b want 000", rbus.rvalid);
        end
    endtask

    task automatic test_dropped_req();
        rbus.req = 3'b100; rbus.we = 3'b100;
        #2;
        rbus.req = '0;
        tick();
        checks++;
        if ({rbus.ack, r_wren, r_rden} !== 5'b0) begin
            fails++; $display("FAIL dropped_req got %b want 00000",
                              {rbus.ack, r_wren, r_rden});
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_ack;
        logic [2:0] prev_ack;
        do_reset();
        rbus.req = 3'b111; rbus.we = 3'b000;
        rbus.addr = 24'h30_20_10;
        prev_ack = 3'b000;
        for (int i = 0; i < 6; i++) begin
            tick();
            exp_ack = 3'b001 << (i % 3);
            checks++;
            if (rbus.ack !== exp_ack || r_rden !== 1'b1) begin
                fails++; $display("FAIL rr_ack[%0d] got %b/%b want %b/1",
                                  i, rbus.ack, r_rden, exp_ack);
            end
            checks++;
            if (rbus.rvalid !== prev_ack) begin
                fails++; $display("FAIL rr_rvalid[%0d] got %b want %b",
                                  i, rbus.rvalid, prev_ack);
            end
            prev_ack = exp_ack;
        end
        rbus.req = '0;
        tick();
        checks++;
        if (rbus.rvalid !== 3'b100 || rbus.ack !== 3'b000) begin
            fails++; $display("FAIL rr_tail got %b/%b want 100/000",
                              rbus.rvalid, rbus.ack);
        end
        tick();
    endtask

    task automatic test_fixed_prio();
        logic [2:0] exp_ack;
        fbus.req = 3'b110; fbus.we = 3'b000;
        fbus.addr = 24'h22_11_00;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_ack = (i % 2 == 0) ? 3'b010 : 3'b100;
            checks++;
            if (fbus.ack !== exp_ack || f_rden !== 1'b1) begin
                fails++; $display("FAIL fp_ack[%0d] got %b/%b want %b/1",
                                  i, fbus.ack, f_rden, exp_ack);
            end
        end
        fbus.req = '0;
        tick();
        checks++;
        if (fbus.rvalid !== 3'b100 || fbus.rdata !== 8'h22) begin
            fails++; $display("FAIL fp_rvalid got %b/%h want 100/22",
                              fbus.rvalid, fbus.rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        rbus.req = 3'b010; rbus.we = 3'b000;
        rbus.addr[15:8] = 8'h77;
        tick();
        checks++;
        if (rbus.ack !== 3'b010) begin
            fails++; $display("FAIL mid_ack got %b want 010", rbus.ack);
        end
        rbus.req = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({rbus.ack, rbus.rvalid, r_wren, r_rden} !== 8'b0) begin
            fails++; $display("FAIL mid_outputs got %b want 00000000",
                              {rbus.ack, rbus.rvalid, r_wren, r_rden});
        end
        checks++;
        if ({r_address, r_data} !== 16'h0000) begin
            fails++; $display("FAIL mid_addr_data got %h want 0000",
                              {r_address, r_data});
        end
        rbus.req = 3'b111;
        tick();
        rbus.req = '0;
        checks++;
        if (rbus.ack !== 3'b001) begin
            fails++; $display("FAIL mid_prio got %b want 001", rbus.ack);
        end
        tick();
        checks++;
        if (rbus.rvalid !== 3'b001) begin
            fails++; $display("FAIL mid_rvalid got %b want 001", rbus.rvalid);
        end
    endtask

    task automatic test_back_to_back();
        rbus.req = 3'b101; rbus.we = 3'b100;
        rbus.addr = 24'h20_99_20;
        rbus.wdata = 24'h3C_55_66;
        tick();
        rbus.req = 3'b001;
        checks++;
        if (rbus.ack !== 3'b100 || r_wren !== 1'b1) begin
            fails++; $display("FAIL b2b_wr_ack got %b/%b want 100/1", rbus.ack, r_wren);
        end
        checks++;
        if ({r_address, r_data} !== 16'h203C) begin
            fails++; $display("FAIL b2b_wr_addr_data got %h want 203c",
                              {r_address, r_data});
        end
        tick();
        rbus.req = '0;
        checks++;
        if (rbus.ack !== 3'b001 || r_rden !== 1'b1 || r_address !== 8'h20) begin
            fails++; $display("FAIL b2b_rd_ack got %b/%b/%h want 001/1/20",
                              rbus.ack, r_rden, r_address);
        end
        checks++;
        if (rbus.rvalid !== 3'b000) begin
            fails++; $display("FAIL b2b_wr_rvalid got %b want 000", rbus.rvalid);
        end
        tick();
        checks++;
        if (rbus.rvalid !== 3'b001 || rbus.rdata !== 8'h3C) begin
            fails++; $display("FAIL b2b_rd_data got %b/%h want 001/3c",
                              rbus.rvalid, rbus.rdata);
        end
        tick();
    endtask

    initial begin
        clock  = 1'b0;
        reset  = 1'b1;
        checks = 0;
        fails  = 0;
        test_reset();
        test_write();
        test_read_back();
        test_dropped_req();
        test_round_robin();
        test_fixed_prio();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/dpram_port_arbiter.md
Name: dpram_port_arbiter

Overview:
- Shares one port (A or B) of a dual-port RAM instance between NREQ requesters, e.g. CPU, video fetch and DMA.
- Uses round-robin or fixed-priority arbitration with a req/ack handshake.
- Issues at most one memory operation per clock.
- Returns read data with a per-requester valid pulse, matching the RAM's registered 1-cycle read.

Parameters:
- NREQ, 3, number of requesters (2..8).
- AW, 8, address width; equals the RAM's widthad_a.
- DW, 8, data width; equals the RAM's width_a.
- FIXED_PRIO, 0, 0 = round-robin; 1 = fixed priority, requester 0 highest.

Ports:
- clock  in  1  single clock; also drives the shared RAM port clock.
- reset  in  1  synchronous, active-high.
- req  in  NREQ  per-requester access request; level, held until ack.
- we  in  NREQ  per-requester write enable; qualifies req (1 = write, 0 = read).
- addr  in  NREQ*AW  packed addresses; requester i uses bits [i*AW +: AW].
- wdata  in  NREQ*DW  packed write data; requester i uses bits [i*DW +: DW].
- ack  out  NREQ  one-cycle grant pulse; one-hot or zero.
- rvalid  out  NREQ  one-cycle read-data-valid pulse; one-hot or zero.
- rdata  out  DW  read data, shared by all requesters; meaningful only while an rvalid bit is set.
- mem_address  out  AW  to the RAM address input.
- mem_data  out  DW  to the RAM data input.
- mem_wren  out  1  to the RAM write enable.
- mem_rden  out  1  to the RAM read enable.
- mem_q  in  DW  from the RAM q output.

Behaviour:
Clocking and reset
- One clock; reset is synchronous and active-high.
- All outputs except rdata are registered.
- Reset values: ack = 0, rvalid = 0, mem_wren = 0, mem_rden = 0, mem_address = 0, mem_data = 0.
- Reset sets the round-robin pointer so requester 0 has highest priority.

Arbitration (every edge)
- Eligible set = req & ~ack. A requester is never granted in the cycle its ack is high; this prevents a double grant on a stale req.
- Round-robin: the highest-priority eligible requester is the first eligible index at or after ptr, wrapping modulo NREQ.
- On each grant, ptr <= granted index + 1 (wrapping). With no grant, ptr holds.
- FIXED_PRIO = 1: the lowest eligible index wins and ptr is unused.

Grant edge (end of cycle T)
- ack[g] <= 1.
- mem_address <= addr[g] and mem_data <= wdata[g].
- mem_wren <= we[g]; mem_rden <= ~we[g].
- No eligible requester: ack <= 0, mem_wren <= 0, mem_rden <= 0, mem_address and mem_data hold.

Timing
- RAM samples the operation at the end of cycle T+1. For reads, mem_q is valid in cycle T+2.
- Read pipeline: a 1-bit valid plus a log2(NREQ)-bit id are delayed one cycle after the grant. rvalid[g] = 1 in cycle T+2.
- rdata = mem_q (combinational pass-through).
- Writes never produce rvalid.
- Latency req-to-ack: 1 cycle when uncontended. Read req-to-rvalid: 2 cycles.
- Throughput: one access per cycle across requesters; at most one access per 2 cycles per requester.
- The requester may change addr/we/wdata or drop req in the cycle after ack (T+2 onward); the arbiter captured them at the grant edge.

Boundary conditions
- req dropped before ack: no access, no ack.
- All requesters asserting continuously, round-robin: grant order 0, 1, 2, 0, 1, 2 … with no idle cycles (NREQ ≥ 2).
- Read and write to the same address in consecutive cycles: executed in grant order. A read following a write returns the new data.
- Reset asserted mid-operation: in-flight rvalid is suppressed (0 in the cycle after reset), ptr is reset, and a RAM op already issued completes harmlessly.
- Unused, non-granted requesters' addr/wdata are ignored.

Test Plan:
- Reset, then req[0] = 1, we[0] = 1, addr = 0x10, wdata = 0xA5 → ack[0] in cycle 1; mem_wren = 1, mem_address = 0x10, mem_data = 0xA5 in cycle 1; no rvalid.
- Read of 0x10 by requester 1 after that write → ack[1] at +1 cycle, mem_rden = 1; rvalid[1] at +2 cycles with rdata = 0xA5.
- req = 3'b111 held, all reads, round-robin → ack sequence 001, 010, 100, 001 …; mem_rden high every cycle; rvalid follows ack by exactly one cycle.
- FIXED_PRIO = 1, req = 3'b110 held → requester 1 granted every other cycle; requester 2 fills the gaps (ack 010, 100, 010, 100).
- Read issued, reset asserted in the ack cycle → rvalid stays 0; all outputs at reset values the next cycle; the next request after release is served in priority order from requester 0.
- Write 0x3C to 0x20 by requester 2, then requester 0 reads 0x20 granted the next cycle → rvalid[0] with rdata = 0x3C.
